uart_rx_engine: RTL
===================

# uart_rx_engine

Synthesizable UART receive engine: it recovers 8-bit frames from an asynchronous serial line using 16x oversampling with 3-sample majority voting. It checks parity, framing and break, and buffers received bytes with their error flags in a small FIFO behind a valid/ready stream. It is the receiving end of the RS232 line that the bench serial model drives into the APB4 UART, and it feeds the register/APB layer of that peripheral.

## Interface
- FIFO_DEPTH, 8, entries in the receive FIFO; power of two, ≥2
- clk_i  in  1  single system clock
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  receiver enable; low aborts any frame in progress
- div_i  in  16  oversample tick period minus one: tick every div_i+1 clocks; div_i = fclk/(16·baud)−1; change only while busy_o=0
- par_en_i  in  1  parity bit present
- par_odd_i  in  1  1 = odd parity, 0 = even parity
- stop2_i  in  1  two stop bits expected
- rx_i  in  1  serial input, asynchronous, idle high
- data_o  out  8  head-of-FIFO byte
- perr_o  out  1  parity error flag of the head entry
- ferr_o  out  1  framing error flag of the head entry
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer pops the head when valid_o&ready_i
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overrun_o  out  1  one-cycle pulse: frame dropped because FIFO full
- break_o  out  1  one-cycle pulse: break detected
- busy_o  out  1  FSM not in IDLE

## Operation
- rx_i passes through a 2-flop synchronizer; both flops reset to 1.
- Tick counter runs only when the FSM is not IDLE. It is cleared on start detection and pulses a tick when it reaches div_i.
- Sample counter is 4 bits (0..15) and advances per tick. The bit value is the majority of the synchronized rx at ticks 7, 8 and 9; the bit decision is made at tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when en_i=1 and synchronized rx=0, clear the counters and go to START.
- START: if the voted bit is 1, the start was false; return to IDLE and push nothing. Otherwise go to DATA.
- DATA: 8 bits, LSB first, shifted into a register. After bit 7, go to PARITY if par_en_i, else STOP.
- PARITY: compare the received bit with the XOR of the data bits, XOR par_odd_i. A mismatch sets the perr flag.
- STOP: a low voted stop bit sets the ferr flag. With stop2_i, both stop bits are checked; ferr is the OR of the two checks.
  - Push {perr, ferr, data} at the decision tick of the last stop bit checked, then go directly to IDLE. This gives back-to-back frames half a bit of margin.
- Break: data=0, parity bit (if present)=0 and first stop bit=0. In that case pulse break_o, push nothing, and go to BREAK. BREAK stays until synchronized rx=1, then goes to IDLE.
- FIFO full at push: the frame is dropped, overrun_o pulses, and the FIFO is unchanged. If a pop happens in the same cycle, the push is accepted and no overrun occurs.
- Simultaneous push and pop when not full: count is unchanged and both operations take effect.
- en_i=0: the FSM goes to IDLE at the next clock and the partial frame is discarded. FIFO contents and the pop path are unaffected.

## Timing
- Reset values: data_o, perr_o, ferr_o, valid_o, count_o, overrun_o, break_o and busy_o are all 0. FSM is IDLE, counters are 0, FIFO is empty.
- Start detection: 2 clocks after the rx_i falling edge (synchronizer), plus 1 clock for the FSM transition.
- Push to visibility: valid_o, data_o and count_o update in the clock after the push cycle.
- Pop: the head advances in the clock after valid_o&ready_i. data_o is registered from FIFO storage, so there is no combinational path from ready_i to data_o.
- Pointers wrap modulo FIFO_DEPTH. count_o distinguishes full from empty.
- overrun_o and break_o are each high for exactly one clock per event.

## Structure
- Package uart_rx_pkg holds:
  - state enum rx_state_e (IDLE, START, DATA, PARITY, STOP, BREAK);
  - entry struct rx_entry_t {perr, ferr, data[7:0]};
  - constants OVERSAMPLE=16 and SAMPLE_MID=8.
- One sub-module, uart_rx_fifo: a synchronous FIFO of rx_entry_t with push/pop, count and registered head output.

## Test plan
- clk 100 MHz, div_i=53 (115200 baud), 8N1, rx frame 0x41 with ready_i=1 → one entry {data 0x41, perr 0, ferr 0}, valid_o high for 1 clock.
- par_en_i=1, par_odd_i=0; frame 0x43 with parity bit 0 (correct is 1) → data 0x43, perr 1; a correct 0x43 frame then gives perr 0.
- rx_i low for 30 clocks only → no push, busy_o back to 0 within 1 bit time.
- Frame 0x55 with stop bit 0 → data 0x55, ferr 1. Line held low ≥2 frame times → break_o pulses once, no push, IDLE after rx returns high.
- ready_i=0, frames 0x41..0x49 back-to-back → count_o=8 holding 0x41..0x48 in order; 9th frame → overrun_o pulse; draining returns 0x41..0x48.
- rst_i asserted mid-DATA, then frame 0x5A → all outputs 0 during reset, FIFO empty, next frame received correctly as 0x5A.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive engine.
//   rx_state_e : receiver FSM states
//   rx_entry_t : one receive FIFO entry {perr, ferr, data}
//   majority3  : 2-of-3 vote used for the per-bit decision
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;  // ticks per bit
    localparam int SAMPLE_MID = 8;   // centre tick; votes at MID-1, MID, MID+1

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO of rx_entry_t with a registered head.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push, wdata  : write request and entry
//   pop          : consumer pop request (ignored when empty)
//   head         : registered head-of-FIFO entry (no path from pop to head)
//   valid        : FIFO not empty
//   count        : occupancy, one bit wider than the pointers so full != empty
//   overrun      : one-cycle pulse when a push was dropped because the FIFO was full
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  rx_entry_t                wdata,
    input  logic                     pop,
    output rx_entry_t                head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rx_entry_t         mem [DEPTH];
    rx_entry_t         head_q, head_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_next;
    logic [CW-1:0]     count_q, count_after_pop;
    logic              do_push, do_pop, full, overrun_q;

    assign full            = (count_q == CW'(DEPTH));
    assign do_pop          = pop && (count_q != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push         = push && (!full || do_pop);
    assign rd_ptr_next     = rd_ptr_q + PW'(do_pop);
    assign count_after_pop = count_q - CW'(do_pop);

    // Next head: the entry being pushed if it lands in an otherwise empty FIFO,
    // else whatever sits at the (possibly advanced) read pointer.
    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        head_d = '0;
        if (do_push && count_after_pop == '0)
            head_d = wdata;
        else if (count_after_pop != '0)
            head_d = mem[rd_ptr_next];
    end

    // NOTE: storage is not reset; count/pointers define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push)
            mem[wr_ptr_q] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + PW'(do_push);
            rd_ptr_q  <= rd_ptr_next;
            count_q   <= count_after_pop + CW'(do_push);
            head_q    <= head_d;
            overrun_q <= push && !do_push;
        end
    end

    assign head    = head_q;
    assign valid   = (count_q != '0);
    assign count   = count_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x-oversampled UART receiver with 3-sample majority vote,
// parity/framing/break checks and a receive FIFO behind a valid/ready stream.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   en_i                : receiver enable; low aborts the frame in progress
//   div_i               : tick period minus one (tick every div_i+1 clocks)
//   par_en_i, par_odd_i : parity present / odd parity
//   stop2_i             : two stop bits expected
//   rx_i                : asynchronous serial input, idle high
//   data_o, perr_o, ferr_o, valid_o, ready_i, count_o : FIFO head stream
//   overrun_o, break_o  : one-cycle event pulses
//   busy_o              : receiver FSM not idle
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [15:0]                   div_i,
    input  logic                          par_en_i,
    input  logic                          par_odd_i,
    input  logic                          stop2_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          perr_o,
    output logic                          ferr_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overrun_o,
    output logic                          break_o,
    output logic                          busy_o
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SAMP_A = SW'(SAMPLE_MID - 1);
    localparam logic [SW-1:0] SAMP_B = SW'(SAMPLE_MID);
    localparam logic [SW-1:0] SAMP_C = SW'(SAMPLE_MID + 1);  // decision tick

    logic              rx_meta, rx_sync;
    rx_state_e         state_q, state_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
    logic              samp_a_q, samp_a_d, samp_b_q, samp_b_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_bit_q, par_bit_d;
    logic              perr_q, perr_d, ferr_q, ferr_d;
    logic              second_stop_q, second_stop_d;
    logic              break_q, break_d;
    logic              tick, decide, voted, push;
    rx_entry_t         push_entry, head;

    assign tick   = (tick_cnt_q == div_i);
    assign decide = (state_q != IDLE) && tick && (samp_cnt_q == SAMP_C);
    assign voted  = majority3(samp_a_q, samp_b_q, rx_sync);

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        samp_cnt_d    = samp_cnt_q;
        samp_a_d      = samp_a_q;
        samp_b_d      = samp_b_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_bit_d     = par_bit_q;
        perr_d        = perr_q;
        ferr_d        = ferr_q;
        second_stop_d = second_stop_q;
        break_d       = 1'b0;
        push          = 1'b0;
        push_entry    = '0;

        // Oversample timing runs continuously across bits of a frame; the
        // 4-bit sample counter wraps every bit.
        if (state_q != IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
            if (tick) begin
                samp_cnt_d = samp_cnt_q + SW'(1);
                if (samp_cnt_q == SAMP_A) samp_a_d = rx_sync;
                if (samp_cnt_q == SAMP_B) samp_b_d = rx_sync;
            end
        end

        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                if (en_i && !rx_sync) begin
                    state_d       = START;
                    bit_cnt_d     = '0;
                    par_bit_d     = 1'b0;
                    perr_d        = 1'b0;
                    ferr_d        = 1'b0;
                    second_stop_d = 1'b0;
                end
            end
            START: begin
                if (decide) state_d = voted ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_d   = {voted, shift_q[7:1]};  // LSB arrives first
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = par_en_i ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide) begin
                    par_bit_d = voted;
                    perr_d    = voted != (^shift_q ^ par_odd_i);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!second_stop_q && shift_q == 8'h00 &&
                        !(par_en_i && par_bit_q) && !voted) begin
                        break_d = 1'b1;
                        state_d = BREAK;
                    end else if (!second_stop_q && stop2_i) begin
                        ferr_d        = !voted;
                        second_stop_d = 1'b1;
                    end else begin
                        // Returning to IDLE at the decision tick leaves half a
                        // bit to catch the next start edge.
                        push       = 1'b1;
                        push_entry = '{perr: perr_q,
                                       ferr: !voted || (second_stop_q && ferr_q),
                                       data: shift_q};
                        state_d    = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rx_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!en_i) begin
            state_d = IDLE;
            push    = 1'b0;
            break_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            samp_cnt_q    <= '0;
            samp_a_q      <= 1'b1;
            samp_b_q      <= 1'b1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_bit_q     <= 1'b0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            second_stop_q <= 1'b0;
            break_q       <= 1'b0;
        end else begin
            rx_meta       <= rx_i;
            rx_sync       <= rx_meta;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            samp_a_q      <= samp_a_d;
            samp_b_q      <= samp_b_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_bit_q     <= par_bit_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
            second_stop_q <= second_stop_d;
            break_q       <= break_d;
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .wdata   (push_entry),
        .pop     (ready_i),
        .head    (head),
        .valid   (valid_o),
        .count   (count_o),
        .overrun (overrun_o)
    );

    assign data_o  = head.data;
    assign perr_o  = head.perr;
    assign ferr_o  = head.ferr;
    assign break_o = break_q;
    assign busy_o  = (state_q != IDLE);

endmodule
